esp_plm_loader: RTL and testbench

Input-load stage between the ESP DMA read interface and the accelerator's 2048x8 PLM. It issues the read requests for matrix A and matrix B, accepts 32-bit DMA beats, and writes each beat to the PLM as four consecutive byte writes. Matrix A goes to addr 0..511 and matrix B to addr 512..1023. The controller pulses `start` after `conf_done`, waits for `done`, then begins compute.

---
 rtl/esp_plm_loader.sv | 184 ++++++++++++++++++
 tb/tb_esp_plm_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/esp_plm_loader.sv
// esp_plm_loader: issues DMA reads for matrices A and B and unpacks each 32-bit beat into four PLM byte writes.
// Optional macro LOADER_PREFETCH_EN accepts the next beat during the last byte write (4 instead of 5 cycles/word).
module esp_plm_loader #(
   parameter int BASE_A    = 0,
   parameter int BASE_B    = 512,
   parameter int MAX_WORDS = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] depth,
   output logic        dma_read_ctrl_valid,
   input  logic        dma_read_ctrl_ready,
   output logic [31:0] dma_read_ctrl_data_index,
   output logic [31:0] dma_read_ctrl_data_length,
   output logic [2:0]  dma_read_ctrl_data_size,
   input  logic        dma_read_chnl_valid,
   output logic        dma_read_chnl_ready,
   input  logic [31:0] dma_read_chnl_data,
   output logic [10:0] plm_a,
   output logic [7:0]  plm_d,
   output logic        plm_ce,
   output logic        plm_we,
   output logic        busy,
   output logic        done,
   output logic        err
);
   typedef enum logic [2:0] {IDLE, REQ, RECV, UNPACK, FIN} state_t;
   state_t      state_q, state_d;
   logic [31:0] len_q, len_d, wc_q, wc_d, buf_q, buf_d, idx_q, idx_d, lng_q, lng_d, wc_inc;
   logic [1:0]  bi_q, bi_d;
   logic [10:0] a_q, a_d;
   logic [7:0]  d_q, d_d;
   logic        phase_q, phase_d, cv_q, cv_d, cr_q, cr_d, we_q, we_d;
   logic        busy_q, busy_d, done_q, done_d, err_q, err_d, beat;

   function automatic logic [10:0] addr_of(input logic ph, input logic [8:0] w, input logic [1:0] b);
      return (ph ? 11'(BASE_B) : 11'(BASE_A)) + {w, 2'b00} + {9'd0, b};
   endfunction

   // Next-state and next-output logic; outputs are computed one cycle ahead so they can all be registered.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wc_d    = wc_q;
      buf_d   = buf_q;
      bi_d    = bi_q;
      phase_d = phase_q;
      cv_d    = cv_q;
      idx_d   = idx_q;
      lng_d   = lng_q;
      cr_d    = 1'b0;
      a_d     = a_q;
      d_d     = d_q;
      we_d    = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      beat    = dma_read_chnl_valid & cr_q;
      wc_inc  = wc_q + 32'd1;
      case (state_q)
         IDLE: if (start) begin
            busy_d = 1'b1;
            if (depth == 32'd0 || depth > 32'(MAX_WORDS)) begin
               state_d = FIN;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               state_d = REQ;
               len_d   = depth;
               phase_d = 1'b0;
               wc_d    = 32'd0;
               cv_d    = 1'b1;
               idx_d   = 32'd0;
               lng_d   = depth;
            end
         end
         REQ: if (dma_read_ctrl_ready) begin
            state_d = RECV;
            cv_d    = 1'b0;
            cr_d    = 1'b1;
         end
         RECV: if (beat) begin
            state_d = UNPACK;
            buf_d   = dma_read_chnl_data;
            bi_d    = 2'd0;
            we_d    = 1'b1;
            d_d     = dma_read_chnl_data[7:0];
            a_d     = addr_of(phase_q, wc_q[8:0], 2'd0);
         end else begin
            cr_d = 1'b1;
         end
         UNPACK: if (bi_q != 2'd3) begin
            bi_d = bi_q + 2'd1;
            we_d = 1'b1;
            d_d  = buf_q[{bi_d, 3'b000} +: 8];
            a_d  = addr_of(phase_q, wc_q[8:0], bi_d);
`ifdef LOADER_PREFETCH_EN
            cr_d = (bi_q == 2'd2) && (wc_inc < len_q);
`endif
         end else if (beat) begin
            wc_d  = wc_inc;
            buf_d = dma_read_chnl_data;
            bi_d  = 2'd0;
            we_d  = 1'b1;
            d_d   = dma_read_chnl_data[7:0];
            a_d   = addr_of(phase_q, wc_inc[8:0], 2'd0);
         end else begin
            wc_d = wc_inc;
            if (wc_inc != len_q) begin
               state_d = RECV;
               cr_d    = 1'b1;
            end else if (!phase_q) begin
               state_d = REQ;
               phase_d = 1'b1;
               wc_d    = 32'd0;
               cv_d    = 1'b1;
               idx_d   = len_q;
               lng_d   = len_q;
            end else begin
               state_d = FIN;
               done_d  = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset abandons any DMA transaction and returns to idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         wc_q    <= '0;
         buf_q   <= '0;
         bi_q    <= '0;
         phase_q <= 1'b0;
         cv_q    <= 1'b0;
         idx_q   <= '0;
         lng_q   <= '0;
         cr_q    <= 1'b0;
         a_q     <= '0;
         d_q     <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wc_q    <= wc_d;
         buf_q   <= buf_d;
         bi_q    <= bi_d;
         phase_q <= phase_d;
         cv_q    <= cv_d;
         idx_q   <= idx_d;
         lng_q   <= lng_d;
         cr_q    <= cr_d;
         a_q     <= a_d;
         d_q     <= d_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign dma_read_ctrl_valid       = cv_q;
   assign dma_read_ctrl_data_index  = idx_q;
   assign dma_read_ctrl_data_length = lng_q;
   assign dma_read_ctrl_data_size   = 3'b010;
   assign dma_read_chnl_ready       = cr_q;
   assign plm_a                     = a_q;
   assign plm_d                     = d_q;
   assign plm_ce                    = we_q;
   assign plm_we                    = we_q;
   assign busy                      = busy_q;
   assign done                      = done_q;
   assign err                       = err_q;
endmodule

// File: tb/tb_esp_plm_loader.sv
// tb_esp_plm_loader: randomized DMA responder plus PLM scoreboard for esp_plm_loader.
module tb_esp_plm_loader;
   localparam int BA = 0, BB = 512;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [31:0] depth = '0;
   logic        dma_read_ctrl_valid, dma_read_ctrl_ready = 1'b0;
   logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
   logic [2:0]  dma_read_ctrl_data_size;
   logic        dma_read_chnl_valid = 1'b0, dma_read_chnl_ready;
   logic [31:0] dma_read_chnl_data = '0;
   logic [10:0] plm_a;
   logic [7:0]  plm_d;
   logic        plm_ce, plm_we, busy, done, err;

   esp_plm_loader dut (
      .clk(clk), .rst(rst), .start(start), .depth(depth),
      .dma_read_ctrl_valid(dma_read_ctrl_valid), .dma_read_ctrl_ready(dma_read_ctrl_ready),
      .dma_read_ctrl_data_index(dma_read_ctrl_data_index), .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
      .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
      .dma_read_chnl_valid(dma_read_chnl_valid), .dma_read_chnl_ready(dma_read_chnl_ready),
      .dma_read_chnl_data(dma_read_chnl_data),
      .plm_a(plm_a), .plm_d(plm_d), .plm_ce(plm_ce), .plm_we(plm_we),
      .busy(busy), .done(done), .err(err)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   logic [31:0] bq [0:255];
   logic [92:0] rst_vec = {1'b0, 32'd0, 32'd0, 3'b010, 1'b0, 11'd0, 8'd0, 5'd0};
   logic [92:0] out_vec;
   assign out_vec = {dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
                     dma_read_ctrl_data_size, dma_read_chnl_ready, plm_a, plm_d, plm_ce, plm_we, busy, done, err};

   // Monitor: records PLM writes, DMA handshakes and done/err pulses at mid-cycle.
   int          cyc = 0, nwr = 0, nreq = 0, ndone = 0, nerr = 0, first_hs = -1, last_a_cyc = 0;
   int          last_wr_cyc = 0, done_cyc = 0, cewe_bad = 0;
   logic [10:0] last_a_addr = '0, last_b_addr = '0;
   logic [31:0] req_idx [0:3], req_len [0:3];
   logic [7:0]  mem [0:2047];
   int          wcnt [0:2047];
   logic        clr = 1'b0;
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         nwr <= 0; nreq <= 0; ndone <= 0; nerr <= 0; first_hs <= -1; cewe_bad <= 0;
         for (int i = 0; i < 2048; i++) begin mem[i] <= '0; wcnt[i] <= 0; end
      end else begin
         if (plm_we) begin
            mem[plm_a] <= plm_d; wcnt[plm_a] <= wcnt[plm_a] + 1; nwr <= nwr + 1; last_wr_cyc <= cyc;
            if (plm_a < 11'd512) begin last_a_addr <= plm_a; last_a_cyc <= cyc; end
            else last_b_addr <= plm_a;
         end
         if (plm_ce !== plm_we) cewe_bad <= cewe_bad + 1;
         if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
            if (nreq < 4) begin req_idx[nreq[1:0]] <= dma_read_ctrl_data_index; req_len[nreq[1:0]] <= dma_read_ctrl_data_length; end
            nreq <= nreq + 1;
         end
         if (dma_read_chnl_valid && dma_read_chnl_ready && first_hs < 0) first_hs <= cyc;
         if (done) begin ndone <= ndone + 1; done_cyc <= cyc; end
         if (err) nerr <= nerr + 1;
      end
   end

   // Reference model: word w of the 2*d loaded words lands at its matrix base, little-endian.
   function automatic int exp_addr(input int w, input int d, input int b);
      return (w < d) ? BA + 4 * w + b : BB + 4 * (w - d) + b;
   endfunction
   function automatic logic [7:0] exp_byte(input int w, input int b);
      logic [31:0] v;
      v = bq[w] >> (8 * b);
      return v[7:0];
   endfunction

   task automatic tick; @(posedge clk); #2; endtask
   task automatic clear_mon; clr = 1'b1; tick(); clr = 1'b0; endtask

   task automatic serve_req(input int stall, output int u, output bit to);
      int g = 0;
      logic [31:0] i0, l0;
      u = 0; to = 1'b0;
      while (!dma_read_ctrl_valid && g < 50) begin tick(); g++; end
      if (!dma_read_ctrl_valid) begin to = 1'b1; return; end
      i0 = dma_read_ctrl_data_index; l0 = dma_read_ctrl_data_length;
      repeat (stall) begin
         tick();
         if (!dma_read_ctrl_valid || dma_read_ctrl_data_index !== i0 || dma_read_ctrl_data_length !== l0) u++;
      end
      dma_read_ctrl_ready = 1'b1; tick(); dma_read_ctrl_ready = 1'b0;
   endtask

   task automatic serve_beats(input int base, input int n, input int pct, output bit to);
      int i = 0, g = 0;
      bit hold = 1'b0, hs;
      to = 1'b0;
      while (i < n) begin
         if (!hold) dma_read_chnl_valid = ($urandom_range(0, 99) < pct);
         dma_read_chnl_data = bq[base + i];
         hs = dma_read_chnl_valid && dma_read_chnl_ready;
         tick(); g++;
         if (hs) begin i++; hold = 1'b0; end else hold = dma_read_chnl_valid;
         if (g > 5000) begin to = 1'b1; break; end
      end
      dma_read_chnl_valid = 1'b0;
   endtask

   task automatic run_load(input int d, input int pct, input int stall, output int unstable, output bit to);
      bit t;
      int u;
      unstable = 0; to = 1'b0;
      clear_mon();
      depth = d; start = 1'b1; tick(); start = 1'b0; depth = $urandom;
      for (int p = 0; p < 2; p++) begin
         serve_req(stall, u, t); unstable += u; to |= t;
         if (t) return;
         serve_beats(p * d, d, pct, t); to |= t;
         if (t) return;
      end
      for (int g = 0; g < 50 && !done; g++) tick();
      to |= !done;
      tick(); tick();
   endtask

   task automatic test_reset;
      rst = 1'b1; tick(); tick();
      checks++;
      if (out_vec !== rst_vec) begin failures++; $display("FAIL reset_values got=%h want=%h", out_vec, rst_vec); end
      rst = 1'b0; tick();
   endtask

   task automatic test_basic;
      int u, a;
      bit t;
      bq[0] = 32'h44332211; bq[1] = 32'h88776655; bq[2] = 32'hDDCCBBAA; bq[3] = 32'h00FFEEDD;
      run_load(2, 100, 0, u, t);
      checks++; if (t) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
      for (int w = 0; w < 4; w++) for (int b = 0; b < 4; b++) begin
         a = exp_addr(w, 2, b); checks++;
         if (mem[a] !== exp_byte(w, b) || wcnt[a] != 1) begin
            failures++; $display("FAIL basic_byte addr=%0d got=%h x%0d want=%h x1", a, mem[a], wcnt[a], exp_byte(w, b));
         end
      end
      checks++;
      if (nreq != 2 || req_idx[0] !== 32'd0 || req_idx[1] !== 32'd2 || req_len[0] !== 32'd2 || req_len[1] !== 32'd2) begin
         failures++; $display("FAIL basic_requests got=%0d idx=%0d,%0d len=%0d,%0d want=2 idx=0,2 len=2,2",
                              nreq, req_idx[0], req_idx[1], req_len[0], req_len[1]);
      end
      checks++;
      if (ndone != 1 || nerr != 0 || nwr != 16) begin
         failures++; $display("FAIL basic_counts got done=%0d err=%0d writes=%0d want 1 0 16", ndone, nerr, nwr);
      end
      checks++;
      if (done_cyc != last_wr_cyc + 1) begin
         failures++; $display("FAIL done_latency got=%0d want=%0d", done_cyc - last_wr_cyc, 1);
      end
      checks++;
      if (cewe_bad != 0) begin failures++; $display("FAIL ce_we_pair got=%0d want=0", cewe_bad); end
   endtask

   task automatic test_error;
      int dv [2] = '{0, 129};
      foreach (dv[k]) begin
         clear_mon();
         depth = dv[k]; start = 1'b1; tick(); start = 1'b0;
         checks++;
         if ({done, err, busy, dma_read_ctrl_valid} !== 4'b1110) begin
            failures++; $display("FAIL err_pulse depth=%0d got=%b want=1110", dv[k], {done, err, busy, dma_read_ctrl_valid});
         end
         tick();
         checks++;
         if ({done, err, busy} !== 3'b000) begin
            failures++; $display("FAIL err_clear depth=%0d got=%b want=000", dv[k], {done, err, busy});
         end
         tick();
         checks++;
         if (nreq != 0 || nwr != 0 || ndone != 1 || nerr != 1) begin
            failures++; $display("FAIL err_side depth=%0d got req=%0d wr=%0d done=%0d err=%0d want 0 0 1 1", dv[k], nreq, nwr, ndone, nerr);
         end
      end
   endtask

   task automatic test_ctrl_stall;
      int d, u, a;
      bit t;
      d = $urandom_range(1, 16);
      for (int w = 0; w < 2 * d; w++) bq[w] = $urandom;
      run_load(d, 70, 10, u, t);
      checks++; if (t) begin failures++; $display("FAIL stall_timeout got=1 want=0"); end
      checks++; if (u != 0) begin failures++; $display("FAIL stall_stable got=%0d want=0", u); end
      for (int w = 0; w < 2 * d; w++) for (int b = 0; b < 4; b++) begin
         a = exp_addr(w, d, b); checks++;
         if (mem[a] !== exp_byte(w, b) || wcnt[a] != 1) begin
            failures++; $display("FAIL stall_byte addr=%0d got=%h x%0d want=%h x1", a, mem[a], wcnt[a], exp_byte(w, b));
         end
      end
      checks++;
      if (ndone != 1 || nwr != 8 * d) begin failures++; $display("FAIL stall_counts got done=%0d wr=%0d want 1 %0d", ndone, nwr, 8 * d); end
   endtask

   task automatic test_throttle;
      int u, a, bad = 0;
      bit t;
      for (int w = 0; w < 256; w++) bq[w] = $urandom;
      run_load(128, 50, 0, u, t);
      checks++; if (t) begin failures++; $display("FAIL throttle_timeout got=1 want=0"); end
      for (int w = 0; w < 256; w++) for (int b = 0; b < 4; b++) begin
         a = exp_addr(w, 128, b);
         if (mem[a] !== exp_byte(w, b) || wcnt[a] != 1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL throttle_bytes got=%0d wrong want=0", bad); end
      checks++;
      if (last_a_addr !== 11'd511 || last_b_addr !== 11'd1023) begin
         failures++; $display("FAIL throttle_last got=%0d,%0d want=511,1023", last_a_addr, last_b_addr);
      end
      checks++; if (ndone != 1 || nwr != 1024) begin failures++; $display("FAIL throttle_counts got done=%0d wr=%0d want 1 1024", ndone, nwr); end
   endtask

   task automatic test_reset_mid;
      int u, a;
      bit t;
      for (int w = 0; w < 8; w++) bq[w] = $urandom;
      clear_mon();
      depth = 8; start = 1'b1; tick(); start = 1'b0;
      serve_req(0, u, t);
      serve_beats(0, 4, 100, t);
      checks++;
      if (plm_we !== 1'b1 || plm_a !== 11'(BA + 12)) begin
         failures++; $display("FAIL mid_unpack got we=%b a=%0d want we=1 a=%0d", plm_we, plm_a, BA + 12);
      end
      #2 rst = 1'b1; #1;
      checks++;
      if (out_vec !== rst_vec) begin failures++; $display("FAIL async_reset got=%h want=%h", out_vec, rst_vec); end
      tick(); rst = 1'b0; tick();
      bq[0] = $urandom; bq[1] = $urandom;
      run_load(1, 100, 0, u, t);
      checks++; if (t) begin failures++; $display("FAIL post_reset_timeout got=1 want=0"); end
      for (int w = 0; w < 2; w++) for (int b = 0; b < 4; b++) begin
         a = exp_addr(w, 1, b); checks++;
         if (mem[a] !== exp_byte(w, b) || wcnt[a] != 1) begin
            failures++; $display("FAIL post_reset_byte addr=%0d got=%h x%0d want=%h x1", a, mem[a], wcnt[a], exp_byte(w, b));
         end
      end
      checks++;
      if (nreq != 2 || req_idx[1] !== 32'd1 || ndone != 1) begin
         failures++; $display("FAIL post_reset_req got req=%0d idx=%0d done=%0d want 2 1 1", nreq, req_idx[1], ndone);
      end
   endtask

   task automatic test_throughput;
      int u, want;
      bit t;
      for (int w = 0; w < 8; w++) bq[w] = $urandom;
      run_load(4, 100, 0, u, t);
`ifdef LOADER_PREFETCH_EN
      want = 4 * 4;
`else
      want = 5 * 4 - 1;
`endif
      checks++; if (t) begin failures++; $display("FAIL tput_timeout got=1 want=0"); end
      checks++;
      if (last_a_cyc - first_hs != want) begin
         failures++; $display("FAIL tput_cycles got=%0d want=%0d", last_a_cyc - first_hs, want);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_error();
      test_ctrl_stall();
      test_throttle();
      test_reset_mid();
      test_throughput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
